// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the AXI read arbiter: FSM states,
// requester index and sticky error bit positions.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK_D,
    ST_LOCK_P
  } arb_state_e;

  typedef enum logic {
    REQ_D = 1'b0,
    REQ_P = 1'b1
  } req_idx_e;

  localparam int ERR_ORPHAN = 0;
  localparam int ERR_OVF    = 1;

endpackage

// File: rtl/axi_rd_arbiter_id_tracker.sv
// Per-ID ownership and outstanding-burst table with one
// increment port, one decrement port and three lookup ports.
module axi_id_tracker
  import axi_rd_arbiter_pkg::*;
#(
  parameter int TID_WIDTH   = 4,
  parameter int OUTST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_inc_en,
  input  logic [TID_WIDTH-1:0]   i_inc_id,
  input  req_idx_e               i_inc_owner,
  input  logic                   i_dec_en,
  input  logic [TID_WIDTH-1:0]   i_dec_id,
  input  logic [TID_WIDTH-1:0]   i_lk_d_id,
  output logic [OUTST_WIDTH-1:0] o_lk_d_cnt,
  output req_idx_e               o_lk_d_own,
  input  logic [TID_WIDTH-1:0]   i_lk_p_id,
  output logic [OUTST_WIDTH-1:0] o_lk_p_cnt,
  output req_idx_e               o_lk_p_own,
  input  logic [TID_WIDTH-1:0]   i_lk_r_id,
  output logic [OUTST_WIDTH-1:0] o_lk_r_cnt,
  output req_idx_e               o_lk_r_own
);

  localparam int DEPTH = 2 ** TID_WIDTH;

  logic [OUTST_WIDTH-1:0] r_cnt [DEPTH];
  req_idx_e               r_own [DEPTH];
  logic [DEPTH-1:0]       w_inc_hit;
  logic [DEPTH-1:0]       w_dec_hit;

  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_inc_hit[i] = i_inc_en &&
                     (i_inc_id == TID_WIDTH'(i));
      w_dec_hit[i] = i_dec_en &&
                     (i_dec_id == TID_WIDTH'(i));
    end
  end

  // Same-cycle increment and decrement cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
        r_own[i] <= REQ_D;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_inc_hit[i])
          r_own[i] <= i_inc_owner;
        if (w_inc_hit[i] && !w_dec_hit[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_inc_hit[i] && w_dec_hit[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  assign o_lk_d_cnt = r_cnt[i_lk_d_id];
  assign o_lk_d_own = r_own[i_lk_d_id];
  assign o_lk_p_cnt = r_cnt[i_lk_p_id];
  assign o_lk_p_own = r_own[i_lk_p_id];
  assign o_lk_r_cnt = r_cnt[i_lk_r_id];
  assign o_lk_r_own = r_own[i_lk_r_id];

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter with ID-ownership R routing.
// Define ARB_STARVE_GUARD_EN to enable the prefetch starvation guard.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_BITS            = 32,
  parameter int TID_WIDTH            = 4,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int BLOCK_DATA_SIZE_BITS = 512,
  parameter int OUTST_WIDTH          = 4,
  parameter int STARVE_LIMIT         = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            d_ar_valid,
  output logic                            d_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]      d_ar_len,
  input  logic [ADDR_BITS-1:0]            d_ar_addr,
  input  logic [TID_WIDTH-1:0]            d_ar_id,
  input  logic                            p_ar_valid,
  output logic                            p_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]      p_ar_len,
  input  logic [ADDR_BITS-1:0]            p_ar_addr,
  input  logic [TID_WIDTH-1:0]            p_ar_id,
  output logic                            m_ar_valid,
  input  logic                            m_ar_ready,
  output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
  output logic [ADDR_BITS-1:0]            m_ar_addr,
  output logic [TID_WIDTH-1:0]            m_ar_id,
  input  logic                            m_r_valid,
  output logic                            m_r_ready,
  input  logic                            m_r_last,
  input  logic [BLOCK_DATA_SIZE_BITS-1:0] m_r_data,
  input  logic [TID_WIDTH-1:0]            m_r_id,
  output logic                            d_r_valid,
  input  logic                            d_r_ready,
  output logic                            d_r_last,
  output logic [BLOCK_DATA_SIZE_BITS-1:0] d_r_data,
  output logic [TID_WIDTH-1:0]            d_r_id,
  output logic                            p_r_valid,
  input  logic                            p_r_ready,
  output logic                            p_r_last,
  output logic [BLOCK_DATA_SIZE_BITS-1:0] p_r_data,
  output logic [TID_WIDTH-1:0]            p_r_id,
  output logic [1:0]                      errorCode
);

  localparam logic [OUTST_WIDTH-1:0] CNT_MAX = '1;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [1:0]             r_err;
  logic [OUTST_WIDTH-1:0] w_d_cnt, w_p_cnt, w_r_cnt;
  req_idx_e               w_d_own, w_p_own, w_r_own;
  logic                   w_live;
  logic                   w_d_elig, w_p_elig;
  logic                   w_d_sat, w_p_sat;
  logic                   w_gnt_d, w_gnt_p;
  logic                   w_p_first;
  logic                   w_ar_hs;
  logic                   w_orphan;
  logic                   w_r_hs_last;

  axi_id_tracker #(
    .TID_WIDTH   (TID_WIDTH),
    .OUTST_WIDTH (OUTST_WIDTH)
  ) u_trk (
    .clk         (clk),
    .reset       (reset),
    .i_inc_en    (w_ar_hs),
    .i_inc_id    (m_ar_id),
    .i_inc_owner (w_gnt_p ? REQ_P : REQ_D),
    .i_dec_en    (w_r_hs_last),
    .i_dec_id    (m_r_id),
    .i_lk_d_id   (d_ar_id),
    .o_lk_d_cnt  (w_d_cnt),
    .o_lk_d_own  (w_d_own),
    .i_lk_p_id   (p_ar_id),
    .o_lk_p_cnt  (w_p_cnt),
    .o_lk_p_own  (w_p_own),
    .i_lk_r_id   (m_r_id),
    .o_lk_r_cnt  (w_r_cnt),
    .o_lk_r_own  (w_r_own)
  );

  // Outputs stay quiet for as long as reset is high.
  assign w_live = !reset;

  assign w_d_elig = d_ar_valid && (w_d_cnt != CNT_MAX) &&
                    (w_d_cnt == '0 || w_d_own == REQ_D);
  assign w_p_elig = p_ar_valid && (w_p_cnt != CNT_MAX) &&
                    (w_p_cnt == '0 || w_p_own == REQ_P);
  assign w_d_sat  = d_ar_valid && (w_d_cnt == CNT_MAX);
  assign w_p_sat  = p_ar_valid && (w_p_cnt == CNT_MAX);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;

  assign w_p_first = (r_starve == SW'(STARVE_LIMIT)) && w_p_elig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve <= '0;
    else if (!p_ar_valid || (r_state == ST_IDLE && w_gnt_p))
      r_starve <= '0;
    else if (r_state == ST_IDLE && w_gnt_d &&
             r_starve != SW'(STARVE_LIMIT))
      r_starve <= r_starve + 1'b1;
  end
`else
  logic w_unused;

  assign w_p_first = 1'b0;
  assign w_unused  = ^STARVE_LIMIT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // A lock state pins the grant until its AR handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_d     = 1'b0;
    w_gnt_p     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_p_first)
          w_gnt_p = 1'b1;
        else if (w_d_elig)
          w_gnt_d = 1'b1;
        else if (w_p_elig)
          w_gnt_p = 1'b1;
        if (w_gnt_d && !m_ar_ready)
          w_state_nxt = ST_LOCK_D;
        if (w_gnt_p && !m_ar_ready)
          w_state_nxt = ST_LOCK_P;
      end
      ST_LOCK_D: begin
        w_gnt_d = 1'b1;
        if (m_ar_ready || !d_ar_valid)
          w_state_nxt = ST_IDLE;
      end
      ST_LOCK_P: begin
        w_gnt_p = 1'b1;
        if (m_ar_ready || !p_ar_valid)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign m_ar_valid = w_live &&
                      ((w_gnt_d && d_ar_valid) ||
                       (w_gnt_p && p_ar_valid));
  assign m_ar_addr  = w_gnt_p ? p_ar_addr : d_ar_addr;
  assign m_ar_len   = w_gnt_p ? p_ar_len  : d_ar_len;
  assign m_ar_id    = w_gnt_p ? p_ar_id   : d_ar_id;
  assign d_ar_ready = w_live && w_gnt_d && m_ar_ready;
  assign p_ar_ready = w_live && w_gnt_p && m_ar_ready;
  assign w_ar_hs    = m_ar_valid && m_ar_ready;

  // Beats for IDs with nothing outstanding are swallowed.
  assign w_orphan  = (w_r_cnt == '0);
  assign d_r_valid = w_live && m_r_valid && !w_orphan &&
                     (w_r_own == REQ_D);
  assign p_r_valid = w_live && m_r_valid && !w_orphan &&
                     (w_r_own == REQ_P);
  assign m_r_ready = w_live &&
                     (w_orphan ||
                      (w_r_own == REQ_P ? p_r_ready : d_r_ready));

  assign d_r_last = m_r_last;
  assign d_r_data = m_r_data;
  assign d_r_id   = m_r_id;
  assign p_r_last = m_r_last;
  assign p_r_data = m_r_data;
  assign p_r_id   = m_r_id;

  assign w_r_hs_last = m_r_valid && m_r_ready &&
                       m_r_last && !w_orphan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      if (m_r_valid && w_orphan)
        r_err[ERR_ORPHAN] <= 1'b1;
      if (w_d_sat || w_p_sat)
        r_err[ERR_OVF] <= 1'b1;
    end
  end

  assign errorCode = r_err;

endmodule
